// File: rtl/core_types_pkg.sv
// ---------------------------------------------------------------------------
// core_types_pkg
//   Shared sizing constants for the core's return address stack.
//   RAS_ENTRIES      : stack depth (must be a power of two so the top pointer
//                      wraps by plain modulo arithmetic)
//   RAS_INDEX_WIDTH  : width of the top-of-stack pointer
//   RAS_TARGET_WIDTH : width of a stored return target, PC[31:1]
//   RAS_COUNT_WIDTH  : width of the occupancy counter, 0..RAS_ENTRIES
// ---------------------------------------------------------------------------
package core_types_pkg;

    localparam int RAS_ENTRIES      = 8;
    localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
    localparam int RAS_TARGET_WIDTH = 31;
    localparam int RAS_COUNT_WIDTH  = RAS_INDEX_WIDTH + 1;

    typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;
    typedef logic [RAS_INDEX_WIDTH-1:0]  ras_index_t;
    typedef logic [RAS_COUNT_WIDTH-1:0]  ras_count_t;

endpackage

// File: rtl/ras.sv
// ---------------------------------------------------------------------------
// ras -- return address stack for the branch predictor.
//   A circular array of RAS_ENTRIES return targets held in flops, a pointer to
//   the top entry and an occupancy count. Calls push, returns pop, and a
//   mispredict restores the pointer/count checkpointed with the branch.
//
// Ports
//   CLK              in   clock
//   nRST             in   asynchronous active-low reset
//   link_valid       in   push request (call predicted this cycle)
//   link_target      in   return address to push
//   ret_valid        in   pop request (return predicted this cycle)
//   ret_target       out  current top-of-stack target
//   ret_empty        out  occupancy is zero
//   ras_index        out  current top pointer (checkpoint value)
//   ras_count        out  current occupancy (checkpoint value)
//   update_valid     in   mispredict restore request, wins over push/pop
//   update_ras_index in   checkpointed pointer to restore
//   update_ras_count in   checkpointed occupancy to restore
// ---------------------------------------------------------------------------
module ras
    import core_types_pkg::*;
(
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_target,
    input  logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic                        ret_empty,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
    input  logic                        update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
    input  logic [RAS_COUNT_WIDTH-1:0]  update_ras_count
);

    ras_target_t entries [RAS_ENTRIES];
    ras_index_t  ptr;
    ras_count_t  count;

    ras_index_t  ptr_inc;
    ras_index_t  ptr_dec;
    logic        full;

    // Pointer arithmetic wraps naturally because the depth is a power of two.
    assign ptr_inc = ptr + RAS_INDEX_WIDTH'(1);
    assign ptr_dec = ptr - RAS_INDEX_WIDTH'(1);
    assign full    = (count == RAS_COUNT_WIDTH'(RAS_ENTRIES));

    // Zero-latency read of the current state.
    assign ret_target = entries[ptr];
    assign ret_empty  = (count == '0);
    assign ras_index  = ptr;
    assign ras_count  = count;

    // Stack update. A restore overrides any push/pop in the same cycle.
    // A push and a pop together replace the top entry in place. A push when
    // full silently overwrites the oldest entry; a pop when empty is ignored.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            ptr   <= '0;
            count <= '0;
        end else if (update_valid) begin
            ptr   <= update_ras_index;
            count <= update_ras_count;
        end else if (link_valid && ret_valid) begin
            entries[ptr] <= link_target;
        end else if (link_valid) begin
            ptr              <= ptr_inc;
            entries[ptr_inc] <= link_target;
            if (!full) begin
                count <= count + RAS_COUNT_WIDTH'(1);
            end
        end else if (ret_valid && (count != '0)) begin
            ptr   <= ptr_dec;
            count <= count - RAS_COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ras.sv
// ---------------------------------------------------------------------------
// tb_ras -- self-checking bench for the return address stack.
//   Directed scenarios followed by randomized push/pop/restore traffic, all
//   compared against a reference model of the stack kept in this file.
// ---------------------------------------------------------------------------
module tb_ras;
    import core_types_pkg::*;

    logic                        CLK;
    logic                        nRST;
    logic                        link_valid;
    logic [RAS_TARGET_WIDTH-1:0] link_target;
    logic                        ret_valid;
    logic [RAS_TARGET_WIDTH-1:0] ret_target;
    logic                        ret_empty;
    logic [RAS_INDEX_WIDTH-1:0]  ras_index;
    logic [RAS_COUNT_WIDTH-1:0]  ras_count;
    logic                        update_valid;
    logic [RAS_INDEX_WIDTH-1:0]  update_ras_index;
    logic [RAS_COUNT_WIDTH-1:0]  update_ras_count;

    int vectors;
    int miscompares;

    // Reference model: a circular buffer of targets, the top slot and occupancy.
    logic [RAS_TARGET_WIDTH-1:0] m_arr [RAS_ENTRIES];
    int m_ptr;
    int m_cnt;

    ras dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .link_valid       (link_valid),
        .link_target      (link_target),
        .ret_valid        (ret_valid),
        .ret_target       (ret_target),
        .ret_empty        (ret_empty),
        .ras_index        (ras_index),
        .ras_count        (ras_count),
        .update_valid     (update_valid),
        .update_ras_index (update_ras_index),
        .update_ras_count (update_ras_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // A restore with more entries than the stack holds is illegal input.
    always @(posedge CLK) begin
        if (nRST && update_valid) begin
            assert (int'(update_ras_count) <= RAS_ENTRIES)
                else $error("[TB] illegal update_ras_count %0d", update_ras_count);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < RAS_ENTRIES; i++) m_arr[i] = '0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // One clock edge of the stack's behaviour, expressed as stack operations.
    task automatic modelStep(input logic push, input logic [RAS_TARGET_WIDTH-1:0] tgt,
                             input logic pop, input logic upd, input int uidx, input int ucnt);
        if (upd) begin
            m_ptr = uidx;
            m_cnt = ucnt;
        end else if (push && pop) begin
            m_arr[m_ptr] = tgt;
        end else if (push) begin
            m_ptr = (m_ptr + 1) % RAS_ENTRIES;
            m_arr[m_ptr] = tgt;
            if (m_cnt < RAS_ENTRIES) m_cnt = m_cnt + 1;
        end else if (pop && m_cnt > 0) begin
            m_ptr = (m_ptr + RAS_ENTRIES - 1) % RAS_ENTRIES;
            m_cnt = m_cnt - 1;
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".ret_target"}, 32'(ret_target), 32'(m_arr[m_ptr]));
        checkOutput({tag, ".ret_empty"},  32'(ret_empty),  32'(m_cnt == 0));
        checkOutput({tag, ".ras_index"},  32'(ras_index),  32'(m_ptr));
        checkOutput({tag, ".ras_count"},  32'(ras_count),  32'(m_cnt));
    endtask

    task automatic driveIdle();
        link_valid       = 1'b0;
        link_target      = '0;
        ret_valid        = 1'b0;
        update_valid     = 1'b0;
        update_ras_index = '0;
        update_ras_count = '0;
    endtask

    // Drive one cycle of inputs, check the current state before the edge,
    // then check the new state just after it.
    task automatic applyStimulus(input string tag, input logic push,
                                 input logic [RAS_TARGET_WIDTH-1:0] tgt, input logic pop,
                                 input logic upd, input int uidx, input int ucnt);
        @(negedge CLK);
        link_valid       = push;
        link_target      = tgt;
        ret_valid        = pop;
        update_valid     = upd;
        update_ras_index = RAS_INDEX_WIDTH'(uidx);
        update_ras_count = RAS_COUNT_WIDTH'(ucnt);
        #1 checkState({tag, ".pre"});
        @(posedge CLK);
        modelStep(push, tgt, pop, upd, uidx, ucnt);
        #1;
        driveIdle();
        checkState({tag, ".post"});
    endtask

    task automatic doReset();
        @(negedge CLK);
        nRST = 1'b0;
        driveIdle();
        modelReset();
        repeat (2) @(posedge CLK);
        #1 checkState("reset");
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic push(input logic [RAS_TARGET_WIDTH-1:0] tgt);
        applyStimulus("push", 1'b1, tgt, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic pop();
        applyStimulus("pop", 1'b0, '0, 1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        int cp_idx;
        int cp_cnt;
        int saved_top;
        vectors     = 0;
        miscompares = 0;
        nRST        = 1'b1;
        driveIdle();
        modelReset();

        // Basic push/push/pop.
        doReset();
        push(31'h100);
        push(31'h200);
        checkOutput("basic.top",   32'(ret_target), 32'h200);
        checkOutput("basic.index", 32'(ras_index),  32'd2);
        checkOutput("basic.count", 32'(ras_count),  32'd2);
        pop();
        checkOutput("basic.pop_top",   32'(ret_target), 32'h100);
        checkOutput("basic.pop_count", 32'(ras_count),  32'd1);

        // Overflow: nine pushes wrap over the oldest entry.
        doReset();
        for (int i = 1; i <= 9; i++) push(RAS_TARGET_WIDTH'(i));
        checkOutput("ovf.count", 32'(ras_count),  32'd8);
        checkOutput("ovf.index", 32'(ras_index),  32'd1);
        checkOutput("ovf.top",   32'(ret_target), 32'h9);
        for (int i = 0; i < 8; i++) begin
            checkOutput("ovf.pop_seq", 32'(ret_target), 32'(9 - i));
            pop();
        end
        checkOutput("ovf.empty", 32'(ret_empty), 32'd1);

        // Pop on an empty stack leaves everything alone.
        doReset();
        pop();
        checkOutput("empty_pop.index", 32'(ras_index),  32'd0);
        checkOutput("empty_pop.count", 32'(ras_count),  32'd0);
        checkOutput("empty_pop.top",   32'(ret_target), 32'd0);
        checkOutput("empty_pop.empty", 32'(ret_empty),  32'd1);

        // Simultaneous push and pop replaces the top in place.
        doReset();
        push(31'h100);
        push(31'h200);
        push(31'h300);
        @(negedge CLK);
        link_valid  = 1'b1;
        link_target = 31'h400;
        ret_valid   = 1'b1;
        #1 checkOutput("pushpop.same_cycle", 32'(ret_target), 32'h300);
        @(posedge CLK);
        modelStep(1'b1, 31'h400, 1'b1, 1'b0, 0, 0);
        #1;
        driveIdle();
        checkOutput("pushpop.next_top",   32'(ret_target), 32'h400);
        checkOutput("pushpop.next_count", 32'(ras_count),  32'd3);
        checkState("pushpop");

        // Checkpoint, speculate three calls, then restore with a coincident push.
        doReset();
        push(31'h100);
        push(31'h200);
        cp_idx    = int'(ras_index);
        cp_cnt    = int'(ras_count);
        saved_top = 32'h200;
        checkOutput("cp.index", 32'(cp_idx), 32'd2);
        checkOutput("cp.count", 32'(cp_cnt), 32'd2);
        push(31'h111);
        push(31'h222);
        push(31'h333);
        applyStimulus("restore", 1'b1, 31'h444, 1'b0, 1'b1, cp_idx, cp_cnt);
        checkOutput("restore.index", 32'(ras_index),  32'd2);
        checkOutput("restore.count", 32'(ras_count),  32'd2);
        checkOutput("restore.top",   32'(ret_target), 32'(saved_top));

        // Reset asserted between clock edges takes effect immediately.
        push(31'h5A5);
        push(31'h6B6);
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst.top",   32'(ret_target), 32'd0);
        checkOutput("async_rst.empty", 32'(ret_empty),  32'd1);
        checkOutput("async_rst.index", 32'(ras_index),  32'd0);
        checkOutput("async_rst.count", 32'(ras_count),  32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Randomized traffic with occasional restores to recorded checkpoints.
        cp_idx = 0;
        cp_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            logic do_push;
            logic do_pop;
            logic do_upd;
            logic [RAS_TARGET_WIDTH-1:0] tgt;
            do_push = ($urandom_range(0, 99) < 45);
            do_pop  = ($urandom_range(0, 99) < 45);
            do_upd  = ($urandom_range(0, 15) == 0);
            tgt     = RAS_TARGET_WIDTH'($urandom());
            if ($urandom_range(0, 7) == 0) begin
                cp_idx = m_ptr;
                cp_cnt = m_cnt;
            end
            applyStimulus("rand", do_push, tgt, do_pop, do_upd, cp_idx, cp_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
